// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and constants for the HI/LO multiply/divide controller.
// Also provides the magnitude helper used when a signed divide feeds the unsigned divider.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DIV_FIX  = 2'd3
  } state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// 32-step restoring divider on unsigned operands; one quotient bit per clock after start.
// start loads the operands, last flags the final iteration edge, abort stops iterating.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  localparam logic [5:0] ITER_LAST = 6'(DIV_ITERS - 1);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] trial;

  // Bit 32 of the trial subtraction is the borrow: set means restore.
  assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      quo_d = dividend;
      rem_d = 32'd0;
      dvs_d = divisor;
      cnt_d = 6'd0;
      run_d = 1'b1;
    end else if (abort) begin
      run_d = 1'b0;
    end else if (run_q) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == ITER_LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      dvs_q <= 32'd0;
      cnt_q <= 6'd0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = run_q && (cnt_q == ITER_LAST);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: MULT commits MUL_LAT edges after accept, DIV 33 edges after, MTHI/MTLO at accept.
// req_ready is low whenever an operation is in flight or flush is high; the issue stage holds the request.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z_s,
  input  logic [63:0] mul_z_u,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int             CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(MUL_LAT - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  op_e           req_op_e;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          accept, div_start, is_sdiv_req;
  logic [31:0]   div_quo, div_rem;
  logic          div_last;
  logic          sdiv, q_neg, r_neg, div0;
  logic [31:0]   q_fix, r_fix;

  assign req_op_e    = op_e'(req_op);
  assign req_ready   = (state_q == ST_IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign div_start   = accept && (req_op_e == OP_DIV || req_op_e == OP_DIVU);
  assign is_sdiv_req = (req_op_e == OP_DIV);

  div_iter u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag32(req_a, is_sdiv_req)),
    .divisor   (mag32(req_b, is_sdiv_req)),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  // The divider works on magnitudes; signs are restored here from the latched raw operands.
  assign sdiv  = (op_q == OP_DIV);
  assign q_neg = sdiv && (a_q[31] ^ b_q[31]);
  assign r_neg = sdiv && a_q[31];
  assign div0  = (b_q == 32'd0);
  assign q_fix = q_neg ? (~div_quo + 32'd1) : div_quo;
  assign r_fix = r_neg ? (~div_rem + 32'd1) : div_rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = req_op_e;
          a_d  = req_a;
          b_d  = req_b;
          case (req_op_e)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL_WAIT;
              cnt_d   = CNT_INIT;
            end
            OP_DIV, OP_DIVU: state_d = ST_DIV_RUN;
            OP_MTHI: begin
              hi_d   = req_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = (op_q == OP_MULT) ? mul_z_s : mul_z_u;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV_RUN: begin
        if (div_last) state_d = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        lo_d    = div0 ? DIV0_QUOT : q_fix;
        hi_d    = div0 ? a_q : r_fix;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mul_a = a_q;
  assign mul_b = b_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
